cache_top: RTL and testbench
============================

// Module: cache_top
// PURPOSE
//  Behavioural two-level (L1/L2) set-associative cache model that counts accesses; no data storage.
//  Consumes a 48-bit address + ASCII op trace; keeps tag/valid/dirty/age state per way.
//  Exposes per-level read/write/hit/miss counters and the tag/set of the current access.
//  Replacement, write and inclusion policies are runtime-selectable for policy studies.
// PARAMETERS
//  BLOCK_BITS   6  log2 block size in bytes (64 B)
//  L1_SET_BITS  4  log2 L1 sets (16)
//  L1_WAYS      2  L1 associativity
//  L2_SET_BITS  6  log2 L2 sets (64)
//  L2_WAYS      4  L2 associativity
// PORTS
//  clk               in   1   clock, all state on rising edge
//  reset             in   1   synchronous, active-high
//  write_policy      in   1   0 write-through/no dirty, 1 write-back
//  replace_policy    in   1   0 FIFO, 1 LRU
//  inclusion_policy  in   2   0 inclusive, 1 exclusive, 2/3 non-inclusive
//  cache_lvl         in   1   1 access enters L1, 0 access goes to L2 only (L1 bypassed)
//  cache_addr        in   48  byte address
//  cache_op          in   8   8'h52 'R' read, 8'h57 'W' write, other = idle
//  L1_reads/L1_writes/L1_hits/L1_misses  out 12 each  L1 counters
//  L2_reads/L2_writes/L2_hits/L2_misses  out 12 each  L2 counters
//  curr_tag          out  32  low 32 bits of tag of last access at entry level
//  curr_set          out  12  set index (zero-extended) of last access at entry level
// BEHAVIOUR
//  - Reset: all valid/dirty/age bits, counters, curr_tag, curr_set = 0.
//  - Tag/set decode: set = addr[BLOCK_BITS+SET_BITS-1:BLOCK_BITS]; tag = remaining upper bits (full width stored).
//  - New request detection: op is R/W and (addr,op) differs from last accepted pair, or first R/W since reset.
//    Inputs held constant for several cycles count once; the exact same (addr,op) twice in a row counts once.
//  - Lookup is combinational; all state/counter updates occur at the clock edge that samples the request.
//    Results are visible on outputs the following cycle. No stall, no handshake.
//  - Counting: each level's read or write counter +1 per request presented to it; hit or miss +1.
//  - Miss handling: write-allocate at both levels. L1 miss issues an L2 read (fill).
//  - Victim selection: lowest-index invalid way first; otherwise FIFO (oldest fill) or LRU (oldest use).
//    The LRU age is refreshed on hits; the FIFO age is not.
//  - Write-through: every L1 write also issues an L2 write; no dirty bits are set.
//  - Write-back: a write sets the dirty bit. Evicting a dirty L1 victim issues an L2 write. Dirty L2 victims are dropped (count only).
//  - Inclusive: an L2 eviction invalidates the matching L1 block (no extra count).
//  - Exclusive: on L1 miss + L2 hit, the block moves to L1 and is invalidated in L2.
//    Every L1 victim is installed into L2 as an L2 write (dirty kept).
//  - Non-inclusive: no cross-level enforcement.
//  - cache_lvl=0: the L2 access is counted as a direct read/write; L1 state and counters are untouched.
//  - Policy inputs may change between requests; they are not applied retroactively.
//  - Reset asserted mid-trace clears everything on that edge; a request on that edge is discarded.
// CONFIGURATION
//  CACHE_CNT_SAT_EN defined: counters saturate at 12'hFFF.
//  CACHE_CNT_SAT_EN undefined: counters wrap modulo 4096.
// TESTING
//  1. cache_lvl=1, write-through, FIFO, inclusive.
//     R 0x7fff493822b8, R 0x7fff493822b0, W 0x7fff493822a8
//     -> L1 r2 w1 h2 m1; L2 r1 w1 h1 m1; curr_set=0xA.
//  2. Test 1 with write_policy=1 -> L2_writes=0, L2 r1 h0 m1.
//  3. FIFO, reads of 0x000,0x400,0x000,0x800,0x000 -> L1 h1 m4.
//     With LRU -> L1 h2 m3.
//  4. cache_lvl=0, R 0x1000 then W 0x1000 -> L1 counters all 0; L2 r1 w1 h1 m1.
//  5. Hold R 0x2000 for 5 cycles, then op=8'h00 -> L1_reads=1, L1_misses=1.
//  6. Exclusive, cache_lvl=1.
//     R 0x000,0x400,0x800 (L1 set0 evicts 0x000 to L2), then R 0x000 -> final access L1 miss, L2 hit;
//     totals L1 m4, L2 h1 w2.

Source files
------------

// File: rtl/cache_top.sv
// Two-level set-associative cache access-count model (tags/state only, no data).
// Optional: CACHE_CNT_SAT_EN makes the 12-bit counters saturate instead of wrap.
module cache_top #(
    parameter int BLOCK_BITS  = 6,
    parameter int L1_SET_BITS = 4,
    parameter int L1_WAYS     = 2,
    parameter int L2_SET_BITS = 6,
    parameter int L2_WAYS     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_policy,
    input  logic        replace_policy,
    input  logic [1:0]  inclusion_policy,
    input  logic        cache_lvl,
    input  logic [47:0] cache_addr,
    input  logic [7:0]  cache_op,
    output logic [11:0] L1_reads,
    output logic [11:0] L1_writes,
    output logic [11:0] L1_hits,
    output logic [11:0] L1_misses,
    output logic [11:0] L2_reads,
    output logic [11:0] L2_writes,
    output logic [11:0] L2_hits,
    output logic [11:0] L2_misses,
    output logic [31:0] curr_tag,
    output logic [11:0] curr_set
);
    localparam int BW    = 48 - BLOCK_BITS;
    localparam int T1W   = BW - L1_SET_BITS;
    localparam int T2W   = BW - L2_SET_BITS;
    localparam int S1N   = 1 << L1_SET_BITS;
    localparam int S2N   = 1 << L2_SET_BITS;
    localparam int W1_IW = (L1_WAYS > 1) ? $clog2(L1_WAYS) : 1;
    localparam int W2_IW = (L2_WAYS > 1) ? $clog2(L2_WAYS) : 1;

    typedef struct packed {
        logic           valid;
        logic           dirty;
        logic [T1W-1:0] tag;
        logic [31:0]    age;
    } l1_ent_t;

    typedef struct packed {
        logic           valid;
        logic           dirty;
        logic [T2W-1:0] tag;
        logic [31:0]    age;
    } l2_ent_t;

    l1_ent_t l1_q [S1N][L1_WAYS];
    l1_ent_t l1_n [S1N][L1_WAYS];
    l2_ent_t l2_q [S2N][L2_WAYS];
    l2_ent_t l2_n [S2N][L2_WAYS];

    logic [47:0]            last_addr;
    logic [7:0]             last_op;
    logic                   seen;
    logic [31:0]            stamp;
    logic                   wr, req, wb, lru, excl, incl;
    logic [BW-1:0]          blk, eb;
    logic [L1_SET_BITS-1:0] s1, es1;
    logic [T1W-1:0]         t1, et1;
    logic [L2_SET_BITS-1:0] s2;
    logic [T2W-1:0]         t2;
    logic                   hit1, free1, hit2, free2, carry;
    logic [W1_IW-1:0]       hw1, v1;
    logic [W2_IW-1:0]       hw2, v2;
    logic [2:0]             s_en, s_wr, s_dirty, s_fill;
    logic [BW-1:0]          s_blk [3];
    logic [1:0]             i1r, i1w, i1h, i1m, i2r, i2w, i2h, i2m;

    assign blk  = cache_addr[47:BLOCK_BITS];
    assign wr   = (cache_op == 8'h57);
    assign req  = (wr || cache_op == 8'h52) &&
                  (!seen || cache_addr != last_addr || cache_op != last_op);
    assign wb   = write_policy;
    assign lru  = replace_policy;
    assign excl = (inclusion_policy == 2'd1);
    assign incl = (inclusion_policy == 2'd0);
    assign s1   = blk[L1_SET_BITS-1:0];
    assign t1   = blk[BW-1:L1_SET_BITS];

    function automatic logic [11:0] bump(input logic [11:0] c, input logic [1:0] n);
        logic [12:0] s;
        s = {1'b0, c} + {11'b0, n};
`ifdef CACHE_CNT_SAT_EN
        return s[12] ? 12'hFFF : s[11:0];
`else
        return s[11:0];
`endif
    endfunction

    // Lookup, victim choice and the resulting next state for one request
    always_comb begin
        l1_n = l1_q;
        l2_n = l2_q;
        {i1r, i1w, i1h, i1m, i2r, i2w, i2h, i2m} = '0;
        {s_en, s_wr, s_dirty, s_fill} = '0;
        s_blk = '{default: '0};
        {hit1, free1, hit2, free2, carry} = '0;
        {hw1, v1, hw2, v2} = '0;
        {s2, t2, eb, es1, et1} = '0;
        if (req && cache_lvl) begin
            for (int i = 0; i < L1_WAYS; i++)
                if (l1_q[s1][i].valid && l1_q[s1][i].tag == t1) begin
                    hit1 = 1'b1;
                    hw1  = W1_IW'(i);
                end
            for (int i = 0; i < L1_WAYS; i++)
                if (!free1 && !l1_q[s1][i].valid) begin
                    free1 = 1'b1;
                    v1    = W1_IW'(i);
                end
            if (!free1)
                for (int i = 1; i < L1_WAYS; i++)
                    if (l1_q[s1][i].age < l1_q[s1][v1].age) v1 = W1_IW'(i);
            if (wr) i1w = 2'd1; else i1r = 2'd1;
            if (hit1) begin
                i1h = 2'd1;
                if (lru) l1_n[s1][hw1].age = stamp;
                if (wr && wb) l1_n[s1][hw1].dirty = 1'b1;
            end else begin
                i1m = 2'd1;
                // Victim goes to L2 when dirty (write-back) or always when exclusive
                if (l1_q[s1][v1].valid && (excl || l1_q[s1][v1].dirty)) begin
                    s_en[0]    = 1'b1;
                    s_wr[0]    = 1'b1;
                    s_dirty[0] = l1_q[s1][v1].dirty;
                    s_blk[0]   = {l1_q[s1][v1].tag, s1};
                end
                s_en[1]   = 1'b1;
                s_fill[1] = 1'b1;
                s_blk[1]  = blk;
            end
            if (wr && !wb) begin
                s_en[2]  = 1'b1;
                s_wr[2]  = 1'b1;
                s_blk[2] = blk;
            end
        end else if (req) begin
            s_en[0]    = 1'b1;
            s_wr[0]    = wr;
            s_dirty[0] = wr && wb;
            s_blk[0]   = blk;
        end
        for (int k = 0; k < 3; k++) begin
            if (s_en[k]) begin
                s2    = s_blk[k][L2_SET_BITS-1:0];
                t2    = s_blk[k][BW-1:L2_SET_BITS];
                hit2  = 1'b0;
                free2 = 1'b0;
                hw2   = '0;
                v2    = '0;
                if (s_wr[k]) i2w = i2w + 2'd1; else i2r = i2r + 2'd1;
                for (int i = 0; i < L2_WAYS; i++)
                    if (l2_n[s2][i].valid && l2_n[s2][i].tag == t2) begin
                        hit2 = 1'b1;
                        hw2  = W2_IW'(i);
                    end
                for (int i = 0; i < L2_WAYS; i++)
                    if (!free2 && !l2_n[s2][i].valid) begin
                        free2 = 1'b1;
                        v2    = W2_IW'(i);
                    end
                if (!free2)
                    for (int i = 1; i < L2_WAYS; i++)
                        if (l2_n[s2][i].age < l2_n[s2][v2].age) v2 = W2_IW'(i);
                if (hit2) begin
                    i2h = i2h + 2'd1;
                    if (lru) l2_n[s2][hw2].age = stamp;
                    if (s_dirty[k]) l2_n[s2][hw2].dirty = 1'b1;
                    // Exclusive fill: the block leaves L2 and carries its dirty bit up
                    if (s_fill[k] && excl) begin
                        carry = l2_n[s2][hw2].dirty;
                        l2_n[s2][hw2].valid = 1'b0;
                    end
                end else begin
                    i2m = i2m + 2'd1;
                    if (!(s_fill[k] && excl)) begin
                        if (l2_n[s2][v2].valid && incl && cache_lvl) begin
                            eb  = {l2_n[s2][v2].tag, s2};
                            es1 = eb[L1_SET_BITS-1:0];
                            et1 = eb[BW-1:L1_SET_BITS];
                            for (int i = 0; i < L1_WAYS; i++)
                                if (l1_n[es1][i].tag == et1) l1_n[es1][i].valid = 1'b0;
                        end
                        l2_n[s2][v2] = '{valid: 1'b1, dirty: s_dirty[k], tag: t2, age: stamp};
                    end
                end
            end
        end
        if (req && cache_lvl && !hit1)
            l1_n[s1][v1] = '{valid: 1'b1, dirty: (wr && wb) || carry, tag: t1, age: stamp};
    end

    // State, counters and last-request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            l1_q      <= '{default: '0};
            l2_q      <= '{default: '0};
            last_addr <= '0;
            last_op   <= '0;
            seen      <= 1'b0;
            stamp     <= '0;
            curr_tag  <= '0;
            curr_set  <= '0;
            {L1_reads, L1_writes, L1_hits, L1_misses} <= '0;
            {L2_reads, L2_writes, L2_hits, L2_misses} <= '0;
        end else begin
            l1_q      <= l1_n;
            l2_q      <= l2_n;
            L1_reads  <= bump(L1_reads, i1r);
            L1_writes <= bump(L1_writes, i1w);
            L1_hits   <= bump(L1_hits, i1h);
            L1_misses <= bump(L1_misses, i1m);
            L2_reads  <= bump(L2_reads, i2r);
            L2_writes <= bump(L2_writes, i2w);
            L2_hits   <= bump(L2_hits, i2h);
            L2_misses <= bump(L2_misses, i2m);
            if (req) begin
                last_addr <= cache_addr;
                last_op   <= cache_op;
                seen      <= 1'b1;
                stamp     <= stamp + 32'd1;
                curr_tag  <= cache_lvl ? 32'(t1) : 32'(blk >> L2_SET_BITS);
                curr_set  <= cache_lvl ? 12'(s1) : 12'(blk[L2_SET_BITS-1:0]);
            end
        end
    end
endmodule

// File: tb/tb_cache_top.sv
// Self-checking bench for cache_top: scenario tasks with a counter scoreboard.
// Expected counter vectors are pushed at stimulus time and popped after the trace settles.
module tb_cache_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_policy = 1'b0;
    logic        replace_policy = 1'b0;
    logic [1:0]  inclusion_policy = 2'd0;
    logic        cache_lvl = 1'b1;
    logic [47:0] cache_addr = '0;
    logic [7:0]  cache_op = 8'h00;
    logic [11:0] L1_reads, L1_writes, L1_hits, L1_misses;
    logic [11:0] L2_reads, L2_writes, L2_hits, L2_misses;
    logic [31:0] curr_tag;
    logic [11:0] curr_set;

    localparam logic [7:0] R = 8'h52;
    localparam logic [7:0] W = 8'h57;

    typedef struct {
        string       name;
        logic [95:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          fails = 0;
    logic [95:0] act;
    logic [47:0] tmp;

    assign act = {L1_reads, L1_writes, L1_hits, L1_misses,
                  L2_reads, L2_writes, L2_hits, L2_misses};

    cache_top dut (
        .clk(clk), .reset(reset), .write_policy(write_policy),
        .replace_policy(replace_policy), .inclusion_policy(inclusion_policy),
        .cache_lvl(cache_lvl), .cache_addr(cache_addr), .cache_op(cache_op),
        .L1_reads(L1_reads), .L1_writes(L1_writes), .L1_hits(L1_hits),
        .L1_misses(L1_misses), .L2_reads(L2_reads), .L2_writes(L2_writes),
        .L2_hits(L2_hits), .L2_misses(L2_misses),
        .curr_tag(curr_tag), .curr_set(curr_set)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] mk(int a, int b, int c, int d,
                                       int f, int g, int h, int k);
        return {12'(a), 12'(b), 12'(c), 12'(d), 12'(f), 12'(g), 12'(h), 12'(k)};
    endfunction

    task automatic go(input logic [47:0] a, input logic [7:0] o);
        @(negedge clk);
        cache_addr = a;
        cache_op   = o;
    endtask

    task automatic settle();
        @(negedge clk);
        cache_op = 8'h00;
    endtask

    task automatic rst(input logic wp, input logic rp, input logic [1:0] ip);
        @(negedge clk);
        reset    = 1'b1;
        cache_op = 8'h00;
        @(negedge clk);
        reset            = 1'b0;
        write_policy     = wp;
        replace_policy   = rp;
        inclusion_policy = ip;
        cache_lvl        = 1'b1;
    endtask

    task automatic test_reset();
        rst(1'b0, 1'b0, 2'd0);
        go(48'h5000, R);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        cache_op = 8'h00;
        @(negedge clk);
        checks++;
        if (act !== '0) begin
            fails++;
            $display("FAIL reset_counters: got %h expected 0", act);
        end
        checks++;
        if (curr_tag !== 32'd0 || curr_set !== 12'd0) begin
            fails++;
            $display("FAIL reset_curr: got tag %h set %h expected 0 0", curr_tag, curr_set);
        end
        go(48'h5000, R);
        sb.push_back('{"reset_then_first_req", mk(1, 0, 0, 1, 1, 0, 0, 1)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_trace(input logic wp);
        rst(wp, 1'b0, 2'd0);
        go(48'h7fff493822b8, R);
        go(48'h7fff493822b0, R);
        go(48'h7fff493822a8, W);
        if (wp) sb.push_back('{"trace_wb", mk(2, 1, 2, 1, 1, 0, 0, 1)});
        else    sb.push_back('{"trace_wt", mk(2, 1, 2, 1, 1, 1, 1, 1)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
        tmp = 48'h7fff493822a8 >> 10;
        checks++;
        if (curr_set !== 12'hA || curr_tag !== tmp[31:0]) begin
            fails++;
            $display("FAIL trace_curr: got tag %h set %h expected %h %h",
                     curr_tag, curr_set, tmp[31:0], 12'hA);
        end
    endtask

    task automatic test_replace(input logic rp);
        rst(1'b0, rp, 2'd0);
        go(48'h000, R);
        go(48'h400, R);
        go(48'h000, R);
        go(48'h800, R);
        go(48'h000, R);
        if (rp) sb.push_back('{"replace_lru", mk(5, 0, 2, 3, 3, 0, 0, 3)});
        else    sb.push_back('{"replace_fifo", mk(5, 0, 1, 4, 4, 0, 1, 3)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_bypass();
        rst(1'b0, 1'b0, 2'd0);
        cache_lvl = 1'b0;
        go(48'h1000, R);
        go(48'h1000, W);
        sb.push_back('{"bypass_l2_only", mk(0, 0, 0, 0, 1, 1, 1, 1)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
        checks++;
        if (curr_tag !== 32'd1 || curr_set !== 12'd0) begin
            fails++;
            $display("FAIL bypass_curr: got tag %h set %h expected 1 0", curr_tag, curr_set);
        end
        cache_lvl = 1'b1;
    endtask

    task automatic test_back_to_back();
        rst(1'b0, 1'b0, 2'd0);
        go(48'h2000, R);
        repeat (4) @(negedge clk);
        sb.push_back('{"hold_counts_once", mk(1, 0, 0, 1, 1, 0, 0, 1)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
        go(48'h2000, R);
        sb.push_back('{"repeat_after_idle", mk(1, 0, 0, 1, 1, 0, 0, 1)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_exclusive();
        rst(1'b0, 1'b0, 2'd1);
        go(48'h000, R);
        go(48'h400, R);
        go(48'h800, R);
        sb.push_back('{"excl_before_refetch", mk(3, 0, 0, 3, 3, 1, 0, 4)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
        go(48'h000, R);
        sb.push_back('{"excl_refetch_l2_hit", mk(4, 0, 0, 4, 4, 2, 1, 5)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_writeback_evict();
        rst(1'b1, 1'b0, 2'd0);
        go(48'h000, W);
        go(48'h400, W);
        go(48'h800, R);
        sb.push_back('{"wb_dirty_evict", mk(1, 2, 0, 3, 3, 1, 1, 3)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_inclusion(input logic [1:0] ip);
        logic [47:0] seq [9];
        seq = '{48'h0000, 48'h1000, 48'h0000, 48'h2000, 48'h0000,
                48'h3000, 48'h0000, 48'h4000, 48'h0000};
        rst(1'b0, 1'b1, ip);
        for (int i = 0; i < 9; i++) go(seq[i], R);
        if (ip == 2'd0) sb.push_back('{"inclusive_back_inval", mk(9, 0, 3, 6, 6, 0, 0, 6)});
        else            sb.push_back('{"noninclusive_keep", mk(9, 0, 4, 5, 5, 0, 0, 5)});
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 4097;
        rst(1'b0, 1'b0, 2'd0);
        for (int i = 0; i < n; i++) go((i % 2 == 1) ? 48'h40 : 48'h0, R);
`ifdef CACHE_CNT_SAT_EN
        sb.push_back('{"counter_saturate", mk(4095, 0, 4095, 2, 2, 0, 0, 2)});
`else
        sb.push_back('{"counter_wrap", mk(1, 0, 4095, 2, 2, 0, 0, 2)});
`endif
        settle();
        e = sb.pop_front();
        checks++;
        if (act !== e.cnt) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.cnt);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_trace(1'b0);
        test_trace(1'b1);
        test_replace(1'b0);
        test_replace(1'b1);
        test_bypass();
        test_back_to_back();
        test_exclusive();
        test_writeback_evict();
        test_inclusion(2'd0);
        test_inclusion(2'd2);
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
